hack_io_port: RTL and testbench

//  Memory-mapped I/O responder on the io_* side of memory_io_bridge (Hack I/O window).

---
 rtl/hack_io_port_if.sv | 21 ++
 rtl/hack_io_port.sv | 199 +++++++++++++++++++
 tb/tb_hack_io_port.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_io_port_if.sv
// Bus between memory_io_bridge and hack_io_port: address, write data/strobe, read data.
interface hack_io_port_if;
    logic [15:0] io_addr;
    logic [15:0] io_data_out;
    logic        io_we;
    logic [15:0] io_data_in;

    modport master (
        output io_addr,
        output io_data_out,
        output io_we,
        input  io_data_in
    );

    modport slave (
        input  io_addr,
        input  io_data_out,
        input  io_we,
        output io_data_in
    );
endinterface

// File: rtl/hack_io_port.sv
// Hack I/O window responder: keyboard FIFO (KBD/KSTAT), 8N1 UART transmitter (UTX)
// and a 16-bit LED register. Reads are combinational; writes land on the rising clk edge.
module hack_io_port #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst_n,
    hack_io_port_if.slave     bus,
    input  logic              key_valid,
    input  logic [15:0]       key_data,
    output logic              uart_tx,
    output logic [15:0]       led
);

    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef logic [PW-1:0]   ptr_t;
    typedef logic [CNTW-1:0] cnt_t;
    typedef logic [CW-1:0]   bcnt_t;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    // Address decode
    logic sel_kbd, sel_kstat, sel_utx, sel_led;
    logic wr_kbd, wr_kstat, wr_utx, wr_led;

    assign sel_kbd   = (bus.io_addr == 16'h6000);
    assign sel_kstat = (bus.io_addr == 16'h6001);
    assign sel_utx   = (bus.io_addr == 16'h6002);
    assign sel_led   = (bus.io_addr == 16'h6003);

    assign wr_kbd    = bus.io_we & sel_kbd;
    assign wr_kstat  = bus.io_we & sel_kstat;
    assign wr_utx    = bus.io_we & sel_utx;
    assign wr_led    = bus.io_we & sel_led;

    // ---------------- Keyboard FIFO ----------------
    logic [15:0] mem [FIFO_DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        fifo_empty, fifo_full, do_push, do_pop;

    // FIFO next state; a pop on the same edge frees the slot for a push into a full FIFO
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == cnt_t'(FIFO_DEPTH));
        do_pop     = wr_kbd & ~fifo_empty;
        do_push    = key_valid & (~fifo_full | do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + cnt_t'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - cnt_t'(1);
        end

        // Clear first so a same-cycle dropped push keeps the flag set
        ovf_d = ovf_q;
        if (wr_kstat) begin
            ovf_d = 1'b0;
        end
        if (key_valid && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO pointer/count/overflow state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= key_data;
        end
    end

    // ---------------- LED register ----------------
    logic [15:0] led_q;

    // LED register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 16'h0000;
        end else if (wr_led) begin
            led_q <= bus.io_data_out;
        end
    end

    assign led = led_q;

    // ---------------- UART transmitter ----------------
    tx_state_e tx_state_q;
    bcnt_t     bcnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       tx_q;
    logic       bit_done, tx_busy, utx_start;

    assign bit_done  = (bcnt_q == bcnt_t'(CLKS_PER_BIT - 1));
    assign tx_busy   = (tx_state_q != StIdle);
    // The edge that ends STOP may accept the next frame directly
    assign utx_start = wr_utx & ((tx_state_q == StIdle) | ((tx_state_q == StStop) & bit_done));

    // 8N1 frame sequencer with registered serial output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= StIdle;
            bcnt_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            bcnt_q <= bit_done ? '0 : bcnt_q + bcnt_t'(1);
            case (tx_state_q)
                StIdle: begin
                    bcnt_q <= '0;
                    if (utx_start) begin
                        tx_state_q <= StStart;
                        shift_q    <= bus.io_data_out[7:0];
                        tx_q       <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        tx_state_q <= StData;
                        tx_q       <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_q      <= 3'd0;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        if (bit_q == 3'd7) begin
                            tx_state_q <= StStop;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        if (utx_start) begin
                            tx_state_q <= StStart;
                            shift_q    <= bus.io_data_out[7:0];
                            tx_q       <= 1'b0;
                        end else begin
                            tx_state_q <= StIdle;
                        end
                    end
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    assign uart_tx = tx_q;

    // ---------------- Read map ----------------
    logic [6:0] count7;
    assign count7 = 7'(count_q);

    // Combinational read data from address and current state
    always_comb begin
        bus.io_data_in = 16'h0000;
        if (sel_kbd) begin
            bus.io_data_in = fifo_empty ? 16'h0000 : mem[rd_ptr_q];
        end else if (sel_kstat) begin
            bus.io_data_in = {8'h00, count7, ovf_q};
        end else if (sel_utx) begin
            bus.io_data_in = {15'b0, tx_busy};
        end else if (sel_led) begin
            bus.io_data_in = led_q;
        end
    end

endmodule

// File: tb/tb_hack_io_port.sv
// Directed bench for hack_io_port with a FIFO model and a UART bit scoreboard.
module tb_hack_io_port;

    localparam int unsigned Depth = 8;
    localparam int unsigned Cpb   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [15:0] key_data;
    logic        uart_tx;
    logic [15:0] led;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_q [$];
    logic        model_ovf;
    logic        exp_bits [$];

    hack_io_port_if bus_if ();

    hack_io_port #(
        .FIFO_DEPTH   (Depth),
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .key_valid (key_valid),
        .key_data  (key_data),
        .uart_tx   (uart_tx),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus_if.io_addr     = addr;
        bus_if.io_data_out = data;
        bus_if.io_we       = 1'b1;
        step();
        bus_if.io_we       = 1'b0;
    endtask

    task automatic read_check(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        bus_if.io_addr = addr;
        #1;
        check(tag, bus_if.io_data_in, exp);
    endtask

    function automatic void model_push(input logic [15:0] code);
        if (model_q.size() < Depth) model_q.push_back(code);
        else model_ovf = 1'b1;
    endfunction

    function automatic void model_pop();
        if (model_q.size() > 0) void'(model_q.pop_front());
    endfunction

    function automatic logic [15:0] exp_kbd();
        return (model_q.size() > 0) ? model_q[0] : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_kstat();
        return {8'h00, 7'(model_q.size()), model_ovf};
    endfunction

    task automatic key_push(input logic [15:0] code);
        key_valid = 1'b1;
        key_data  = code;
        step();
        key_valid = 1'b0;
        model_push(code);
    endtask

    task automatic kbd_pop();
        bus_write(16'h6000, 16'h1234);
        model_pop();
    endtask

    task automatic push_expected_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(1'b1);
    endtask

    initial begin
        logic b;
        rst_n              = 1'b0;
        key_valid          = 1'b0;
        key_data           = 16'h0000;
        bus_if.io_addr     = 16'h0000;
        bus_if.io_data_out = 16'h0000;
        bus_if.io_we       = 1'b0;
        model_ovf          = 1'b0;

        // Reset state
        #12;
        check("rst_uart_tx", {15'b0, uart_tx}, 16'h0001);
        check("rst_led", led, 16'h0000);
        read_check(16'h6001, 16'h0000, "rst_kstat");
        read_check(16'h6000, 16'h0000, "rst_kbd");
        rst_n = 1'b1;
        step();

        // FIFO order
        key_push(16'h0041);
        key_push(16'h0042);
        read_check(16'h6000, exp_kbd(), "fifo_head_41");
        kbd_pop();
        read_check(16'h6000, exp_kbd(), "fifo_head_42");
        kbd_pop();
        read_check(16'h6000, exp_kbd(), "fifo_empty_read");
        kbd_pop();
        read_check(16'h6001, exp_kstat(), "fifo_pop_empty_kstat");

        // Full and overflow
        for (int i = 1; i <= 9; i++) key_push(16'(i));
        read_check(16'h6001, exp_kstat(), "full_ovf_kstat");
        bus_write(16'h6001, 16'hFFFF);
        model_ovf = 1'b0;
        read_check(16'h6001, exp_kstat(), "ovf_clear_kstat");
        for (int i = 1; i <= 8; i++) begin
            read_check(16'h6000, exp_kbd(), $sformatf("drain_%0d", i));
            kbd_pop();
        end
        read_check(16'h6000, exp_kbd(), "drained_kbd");

        // Simultaneous push and pop on a full FIFO
        for (int i = 1; i <= 8; i++) key_push(16'(i + 16'h0010));
        bus_if.io_addr = 16'h6000;
        bus_if.io_we   = 1'b1;
        key_valid      = 1'b1;
        key_data       = 16'h00AA;
        step();
        bus_if.io_we = 1'b0;
        key_valid    = 1'b0;
        model_pop();
        model_push(16'h00AA);
        read_check(16'h6001, exp_kstat(), "full_pushpop_kstat");
        for (int i = 0; i < 7; i++) kbd_pop();
        read_check(16'h6000, exp_kbd(), "full_pushpop_aa");
        kbd_pop();
        read_check(16'h6001, exp_kstat(), "after_aa_kstat");

        // Simultaneous push and pop on an empty FIFO
        bus_if.io_addr = 16'h6000;
        bus_if.io_we   = 1'b1;
        key_valid      = 1'b1;
        key_data       = 16'h0055;
        step();
        bus_if.io_we = 1'b0;
        key_valid    = 1'b0;
        model_pop();
        model_push(16'h0055);
        read_check(16'h6001, exp_kstat(), "empty_pushpop_kstat");
        read_check(16'h6000, exp_kbd(), "empty_pushpop_head");
        kbd_pop();

        // Push into full FIFO with a KSTAT write on the same edge: set wins
        for (int i = 0; i < 8; i++) key_push(16'(i + 16'h0020));
        bus_if.io_addr = 16'h6001;
        bus_if.io_we   = 1'b1;
        key_valid      = 1'b1;
        key_data       = 16'h00EE;
        step();
        bus_if.io_we = 1'b0;
        key_valid    = 1'b0;
        model_ovf    = 1'b0;
        model_push(16'h00EE);
        read_check(16'h6001, exp_kstat(), "ovf_set_wins");
        for (int i = 0; i < 8; i++) kbd_pop();
        bus_write(16'h6001, 16'h0000);
        model_ovf = 1'b0;
        read_check(16'h6001, exp_kstat(), "fifo_final_kstat");

        // UART frame 0xA5, ignored write while busy, back-to-back frame 0x3C
        bus_write(16'h6002, 16'h00A5);
        push_expected_frame(8'hA5);
        push_expected_frame(8'h3C);
        bus_if.io_data_out = 16'h00FF;
        for (int k = 0; k < 10; k++) begin
            b = exp_bits.pop_front();
            for (int c = 0; c < Cpb; c++) begin
                check($sformatf("utx_a5_bit%0d_c%0d", k, c), {15'b0, uart_tx}, {15'b0, b});
                if (c == 0) read_check(16'h6002, 16'h0001, $sformatf("utx_busy_bit%0d", k));
                bus_if.io_we = ((k == 3) && (c == 1)) || ((k == 9) && (c == Cpb - 1));
                if ((k == 9) && (c == Cpb - 1)) bus_if.io_data_out = 16'h003C;
                step();
                bus_if.io_we = 1'b0;
            end
        end
        bus_if.io_data_out = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            b = exp_bits.pop_front();
            check($sformatf("utx_3c_bit%0d", k), {15'b0, uart_tx}, {15'b0, b});
            read_check(16'h6002, 16'h0001, $sformatf("utx_3c_busy%0d", k));
            for (int c = 0; c < Cpb; c++) step();
        end
        read_check(16'h6002, 16'h0000, "utx_idle");
        check("utx_idle_line", {15'b0, uart_tx}, 16'h0001);

        // Decode and LED
        bus_write(16'h6003, 16'h1234);
        check("led_value", led, 16'h1234);
        read_check(16'h6003, 16'h1234, "led_read");
        bus_write(16'h6004, 16'hFFFF);
        check("led_unmapped_write", led, 16'h1234);
        read_check(16'h6004, 16'h0000, "read_6004");
        read_check(16'h7FFF, 16'h0000, "read_7fff");

        // Reset asserted mid-frame
        key_push(16'h0007);
        bus_write(16'h6002, 16'h0000);
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_tx", {15'b0, uart_tx}, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check("midrst_uart_tx", {15'b0, uart_tx}, 16'h0001);
        check("midrst_led", led, 16'h0000);
        read_check(16'h6001, exp_kstat(), "midrst_kstat");
        read_check(16'h6000, exp_kbd(), "midrst_kbd");
        read_check(16'h6002, 16'h0000, "midrst_busy");
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_tx", {15'b0, uart_tx}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
